// File: rtl/sharpen_filter.sv
// Purpose: 3x3 sharpen (centre CENTER_WEIGHT, neighbours -1) over a 2**AW square gray image.
// Latency: 2*DIM + 1 cycles to first write, DIM*DIM*2 + 2 cycles from start to filter_done.
// Backpressure: none; reads and writes every cycle on a fixed schedule, start ignored while busy.
//
// Ports: clk/rst_n (sync active-low), start pulse, in_pix read data for (row,col),
//        out_row/out_col/out_we/out_pix output image write port, busy, filter_done level.
// Build option: SHARPEN_EDGE_REPLICATE_EN clamps border neighbours instead of zero padding.
module sharpen_filter #(
  parameter int AW            = 6,
  parameter int CENTER_WEIGHT = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [23:0]   in_pix,
  output logic [AW-1:0] row,
  output logic [AW-1:0] col,
  output logic [AW-1:0] out_row,
  output logic [AW-1:0] out_col,
  output logic          out_we,
  output logic [23:0]   out_pix,
  output logic          busy,
  output logic          filter_done
);

  localparam int DIM = 1 << AW;
  localparam logic [AW-1:0] LAST   = '1;
  localparam logic [AW-1:0] PENULT = {{(AW-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {IDLE, PREFILL, FILL, COMPUTE, DONE} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] cnt;     // column counter shared by load and compute phases
  logic [AW-1:0] r;       // row currently being (or about to be) computed
  logic [1:0]    ptr;     // line buffer holding row r; ptr-1 holds r-1, ptr+1 holds r+1
  logic [1:0]    top_ptr, bot_ptr;
  logic [7:0]    lb [0:2][0:DIM-1];

  logic [7:0] gray;
  logic       unused_pix;
  assign gray       = in_pix[15:8];
  assign unused_pix = ^{in_pix[23:16], in_pix[7:0]};

  logic last_col;
  assign last_col = (cnt == LAST);
  assign top_ptr  = (ptr == 2'd0) ? 2'd2 : ptr - 2'd1;
  assign bot_ptr  = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;

  // Read addresses only move while loading; parked at 0 otherwise.
  assign row = (state == FILL) ? r + AW'(1) : '0;
  assign col = (state == PREFILL || state == FILL) ? cnt : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = PREFILL;
      PREFILL: if (last_col) state_nx = FILL;
      FILL:    if (last_col) state_nx = COMPUTE;
      COMPUTE: begin
        if (last_col) begin
          if (r == LAST)        state_nx = DONE;
          else if (r == PENULT) state_nx = COMPUTE;  // row DIM does not exist, nothing to load
          else                  state_nx = FILL;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Line buffers carry no reset; contents are always rewritten before use.
  always_ff @(posedge clk) begin
    if (state == PREFILL)   lb[ptr][cnt]     <= gray;
    else if (state == FILL) lb[bot_ptr][cnt] <= gray;
  end

  // Neighbour selection: either mask out-of-range taps or clamp them onto the border.
  logic [1:0]    rt, rb;
  logic [AW-1:0] cl, cr;
  logic          vt, vb, vl, vr;

  always_comb begin
`ifdef SHARPEN_EDGE_REPLICATE_EN
    rt = (r == '0)   ? ptr : top_ptr;
    rb = (r == LAST) ? ptr : bot_ptr;
    cl = (cnt == '0) ? cnt : cnt - AW'(1);
    cr = last_col    ? cnt : cnt + AW'(1);
    vt = 1'b1;
    vb = 1'b1;
    vl = 1'b1;
    vr = 1'b1;
`else
    rt = top_ptr;
    rb = bot_ptr;
    cl = cnt - AW'(1);
    cr = cnt + AW'(1);
    vt = (r != '0);
    vb = (r != LAST);
    vl = (cnt != '0);
    vr = !last_col;
`endif
  end

  logic [7:0]        p_c, p_tl, p_t, p_tr, p_l, p_r, p_bl, p_b, p_br;
  logic [11:0]       nsum;
  logic signed [15:0] acc;
  logic [7:0]        sharp;

  always_comb begin
    p_c  = lb[ptr][cnt];
    p_tl = (vt && vl) ? lb[rt][cl]  : 8'd0;
    p_t  = vt         ? lb[rt][cnt] : 8'd0;
    p_tr = (vt && vr) ? lb[rt][cr]  : 8'd0;
    p_l  = vl         ? lb[ptr][cl] : 8'd0;
    p_r  = vr         ? lb[ptr][cr] : 8'd0;
    p_bl = (vb && vl) ? lb[rb][cl]  : 8'd0;
    p_b  = vb         ? lb[rb][cnt] : 8'd0;
    p_br = (vb && vr) ? lb[rb][cr]  : 8'd0;
    nsum = 12'(p_tl) + 12'(p_t) + 12'(p_tr) + 12'(p_l)
         + 12'(p_r)  + 12'(p_bl) + 12'(p_b) + 12'(p_br);
    acc  = signed'(16'(CENTER_WEIGHT) * {8'd0, p_c} - {4'd0, nsum});
    if (acc < 0)              sharp = 8'd0;
    else if (acc > 16'sd255)  sharp = 8'd255;
    else                      sharp = acc[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      r           <= '0;
      ptr         <= 2'd0;
      out_row     <= '0;
      out_col     <= '0;
      out_pix     <= 24'd0;
      out_we      <= 1'b0;
      busy        <= 1'b0;
      filter_done <= 1'b0;
    end else begin
      out_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt         <= '0;
            r           <= '0;
            ptr         <= 2'd0;
            busy        <= 1'b1;
            filter_done <= 1'b0;
          end
        end
        PREFILL, FILL: cnt <= cnt + AW'(1);
        COMPUTE: begin
          out_we  <= 1'b1;
          out_row <= r;
          out_col <= cnt;
          out_pix <= {8'd0, sharp, 8'd0};
          cnt     <= cnt + AW'(1);
          if (last_col && r != LAST) begin
            r   <= r + AW'(1);
            ptr <= bot_ptr;   // old centre becomes top, oldest buffer is refilled
          end
        end
        DONE: begin
          busy        <= 1'b0;
          filter_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sharpen_filter.sv
module tb_sharpen_filter;
  localparam int AW = 6;
  localparam int N  = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [23:0]   in_pix;
  logic [AW-1:0] row, col, out_row, out_col;
  logic          out_we;
  logic [23:0]   out_pix;
  logic          busy, filter_done;

  sharpen_filter #(.AW(AW), .CENTER_WEIGHT(9)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_pix(in_pix),
    .row(row), .col(col), .out_row(out_row), .out_col(out_col),
    .out_we(out_we), .out_pix(out_pix), .busy(busy), .filter_done(filter_done)
  );

  always #5 clk = ~clk;

  int img [N][N];
  int got [N][N];

  always_comb in_pix = {8'd0, 8'(img[row][col]), 8'd0};

  int     n_cmp = 0;
  int     n_bad = 0;
  int     wr_idx = 0;
  bit     expect_writes = 1'b0;
  longint gcyc = 0;
  longint last_wr_cyc = 0;
  int     er, ec;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: direct 3x3 convolution over the stored image.
  function automatic int model(input int r, input int c);
    int acc = 0;
    int rr, cc;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr;
        cc = c + dc;
`ifdef SHARPEN_EDGE_REPLICATE_EN
        if (rr < 0) rr = 0;
        if (rr > N-1) rr = N-1;
        if (cc < 0) cc = 0;
        if (cc > N-1) cc = N-1;
`else
        if (rr < 0 || rr > N-1 || cc < 0 || cc > N-1) continue;
`endif
        if (dr == 0 && dc == 0) acc += 9 * img[rr][cc];
        else                    acc -= img[rr][cc];
      end
    end
    if (acc < 0)   return 0;
    if (acc > 255) return 255;
    return acc;
  endfunction

  always @(posedge clk) gcyc++;

  // Every write is checked: raster order, contiguity within a row, pixel value.
  always @(negedge clk) begin
    if (rst_n && out_we) begin
      if (!expect_writes || wr_idx >= N*N) begin
        chk("unexpected_write", int'(out_we), 0);
      end else begin
        er = wr_idx / N;
        ec = wr_idx % N;
        chk("wr_row", int'(out_row), er);
        chk("wr_col", int'(out_col), ec);
        chk("wr_pix", int'(out_pix), int'({8'd0, 8'(model(er, ec)), 8'd0}));
        if (ec != 0) chk("wr_contig", int'(gcyc - last_wr_cyc), 1);
        got[er][ec] = int'(out_pix[15:8]);
        last_wr_cyc = gcyc;
        wr_idx++;
      end
    end
  end

  task automatic run(input int glitch_at, input int abort_at);
    int cyc;
    bit done_seen;
    wr_idx = 0;
    expect_writes = 1'b1;
    @(negedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    done_seen = 1'b0;
    while (!done_seen && cyc < 9000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk("busy_after_start", int'(busy), 1);
        chk("done_cleared", int'(filter_done), 0);
      end
      if (cyc == glitch_at) begin
        #1 start = 1'b1;
        @(negedge clk);
        cyc++;
        #1 start = 1'b0;
      end
      if (cyc == abort_at) begin
        #1 rst_n = 1'b0;
        expect_writes = 1'b0;
        @(negedge clk);
        chk("abort_we", int'(out_we), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(filter_done), 0);
        #1 rst_n = 1'b1;
        repeat (300) @(negedge clk);
        chk("abort_idle_busy", int'(busy), 0);
        return;
      end
      if (filter_done) done_seen = 1'b1;
    end
    chk("done_cycle", cyc, 8194);
    chk("busy_at_done", int'(busy), 0);
    chk("write_count", wr_idx, N*N);
    chk("last_write_before_done", int'(gcyc - last_wr_cyc), 1);
    expect_writes = 1'b0;
    repeat (4) @(negedge clk);
    chk("done_held", int'(filter_done), 1);
  endtask

`ifdef SHARPEN_EDGE_REPLICATE_EN
  localparam int EDGE_UNI = 100;
`else
  localparam int EDGE_UNI = 255;
`endif

  initial begin
    foreach (img[i, j]) img[i][j] = 0;
    repeat (3) @(negedge clk);
    chk("rst_row", int'(row), 0);
    chk("rst_col", int'(col), 0);
    chk("rst_out_row", int'(out_row), 0);
    chk("rst_out_col", int'(out_col), 0);
    chk("rst_out_pix", int'(out_pix), 0);
    chk("rst_out_we", int'(out_we), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(filter_done), 0);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Uniform gray 100
    foreach (img[i, j]) img[i][j] = 100;
    run(0, 0);
    chk("uni_interior", got[32][32], 100);
    chk("uni_edge", got[0][10], EDGE_UNI);
    chk("uni_corner", got[0][0], EDGE_UNI);
    chk("uni_corner_br", got[63][63], EDGE_UNI);

    // All zero
    foreach (img[i, j]) img[i][j] = 0;
    run(0, 0);
    chk("zero_pix", got[40][7], 0);

    // Single bright pixel
    img[10][10] = 200;
    run(0, 0);
    chk("dot_center", got[10][10], 255);
    chk("dot_nbr_diag", got[9][11], 0);
    chk("dot_nbr_below", got[11][10], 0);
    chk("dot_far", got[30][30], 0);

    // Horizontal gradient
    foreach (img[i, j]) img[i][j] = j * 4;
    run(0, 0);
    chk("grad_interior", got[5][20], 80);
    chk("grad_left", got[5][0], 0);
    chk("grad_right", got[5][63], 255);

    // Random image, with a start pulse while busy
    foreach (img[i, j]) img[i][j] = int'($urandom_range(255, 0));
    run(500, 0);

    // Restart after done
    foreach (img[i, j]) img[i][j] = int'($urandom_range(255, 0));
    run(0, 0);

    // Abort by reset mid-run, then a clean full run
    run(0, 3000);
    foreach (img[i, j]) img[i][j] = int'($urandom_range(255, 0));
    run(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
